// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus between the fetch stage and its environment.
//   master : run control (start), instruction-memory data, controller decisions
//   slave  : fetch_unit side; returns address, TYP/OP, instr_valid, done, count
interface fetch_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [INSTR_W-1:0] instr_in;
  logic               br_ctrl;
  logic               jmp_ctrl;
  logic               br_cond;
  logic [7:0]         target;
  logic [PC_W-1:0]    instr_addr;
  logic               typ;
  logic [3:0]         op;
  logic               instr_valid;
  logic               done;
  logic [CNT_W-1:0]   cycle_cnt;

  modport master (
    output start, instr_in, br_ctrl, jmp_ctrl, br_cond, target,
    input  instr_addr, typ, op, instr_valid, done, cycle_cnt
  );

  modport slave (
    input  start, instr_in, br_ctrl, jmp_ctrl, br_cond, target,
    output instr_addr, typ, op, instr_valid, done, cycle_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, drives the instruction
// address, slices TYP/OP for the controller, applies branch/jump decisions on
// the next edge and runs IDLE -> RUN -> HALT with a start/done handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_unit_if.slave (start, instr_in, br_ctrl, jmp_ctrl, br_cond,
//           target in; instr_addr, typ, op, instr_valid, done, cycle_cnt out)
module fetch_unit #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h0FF,
  parameter int                 CNT_W      = 16
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cnt;
  logic             done_q;

  logic             is_halt;
  logic             exec;
  logic [PC_W-1:0]  pc_next;

  assign is_halt = (bus.instr_in == HALT_INSTR);
  // The halt word itself is not executed: valid drops in the cycle it appears.
  assign exec    = (state == RUN) && !is_halt;

  // Jump outranks branch; offsets wrap modulo 2^PC_W by plain truncation.
  always_comb begin
    pc_next = pc + 1'b1;
    if (bus.jmp_ctrl)
      pc_next = {{(PC_W-8){1'b0}}, bus.target};
    else if (bus.br_ctrl && bus.br_cond)
      pc_next = pc + {{(PC_W-8){bus.target[7]}}, bus.target};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= START_ADDR;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (bus.start) begin
            state  <= RUN;
            pc     <= START_ADDR;
            cnt    <= '0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          if (is_halt) begin
            state  <= HALT;
            done_q <= 1'b1;
          end else begin
            pc <= pc_next;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          pc     <= START_ADDR;
          cnt    <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_addr  = pc;
  assign bus.typ         = bus.instr_in[INSTR_W-1];
  assign bus.op          = bus.instr_in[INSTR_W-2 -: 4];
  assign bus.instr_valid = exec;
  assign bus.done        = done_q;
  assign bus.cycle_cnt   = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int PC_W = 10, INSTR_W = 9, CNT_W = 16;
  localparam logic [8:0] HALT_W = 9'h0FF;
  localparam logic [8:0] NOP    = 9'h001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();
  fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_q[$];

  typedef struct {
    logic       start, jmp, br, cond;
    logic [7:0] tgt;
    logic [8:0] instr;
    logic       exp_valid, exp_typ;
    logic [3:0] exp_op;
    logic [9:0] exp_pc;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  function automatic vec_t mk(logic s, logic j, logic b, logic c, logic [7:0] t,
                              logic [8:0] i, logic v, logic ty, logic [3:0] o,
                              logic [9:0] pc);
    vec_t r;
    r.start = s; r.jmp = j; r.br = b; r.cond = c; r.tgt = t; r.instr = i;
    r.exp_valid = v; r.exp_typ = ty; r.exp_op = o; r.exp_pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic j, input logic b, input logic c,
                       input logic [7:0] t, input logic [8:0] i);
    bus.start = s; bus.jmp_ctrl = j; bus.br_ctrl = b; bus.br_cond = c;
    bus.target = t; bus.instr_in = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected address for the next cycle is queued before the edge and
  // compared against instr_addr once the edge has passed.
  task automatic step_pc(input string name, input logic [PC_W-1:0] nxt);
    exp_q.push_back(nxt);
    tick();
    chk(name, 32'(bus.instr_addr), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int nvalid;
    tbl[0]  = mk(1, 1, 0, 0, 8'h10, NOP,    1, 0, 4'h0, 10'h010); // start ignored in RUN
    tbl[1]  = mk(0, 0, 1, 1, 8'hFC, NOP,    1, 0, 4'h0, 10'h00C);
    tbl[2]  = mk(0, 1, 0, 0, 8'h10, NOP,    1, 0, 4'h0, 10'h010);
    tbl[3]  = mk(0, 0, 1, 0, 8'hFC, NOP,    1, 0, 4'h0, 10'h011);
    tbl[4]  = mk(0, 1, 0, 0, 8'h20, NOP,    1, 0, 4'h0, 10'h020);
    tbl[5]  = mk(0, 1, 1, 1, 8'h80, NOP,    1, 0, 4'h0, 10'h080);
    tbl[6]  = mk(0, 1, 0, 0, 8'hFF, NOP,    1, 0, 4'h0, 10'h0FF);
    tbl[7]  = mk(0, 0, 1, 1, 8'h7F, NOP,    1, 0, 4'h0, 10'h17E);
    tbl[8]  = mk(0, 0, 1, 1, 8'h7F, NOP,    1, 0, 4'h0, 10'h1FD);
    tbl[9]  = mk(0, 0, 1, 1, 8'h7F, NOP,    1, 0, 4'h0, 10'h27C);
    tbl[10] = mk(0, 0, 1, 1, 8'h7F, NOP,    1, 0, 4'h0, 10'h2FB);
    tbl[11] = mk(0, 0, 1, 1, 8'h7F, NOP,    1, 0, 4'h0, 10'h37A);
    tbl[12] = mk(0, 0, 1, 1, 8'h7F, NOP,    1, 0, 4'h0, 10'h3F9);
    tbl[13] = mk(0, 0, 1, 1, 8'h06, NOP,    1, 0, 4'h0, 10'h3FF);
    tbl[14] = mk(0, 0, 0, 0, 8'h00, 9'h1A3, 1, 1, 4'hA, 10'h000); // pc wraps to 0
    tbl[15] = mk(0, 1, 0, 0, 8'h02, NOP,    1, 0, 4'h0, 10'h002);
    tbl[16] = mk(0, 0, 1, 1, 8'hFC, NOP,    1, 0, 4'h0, 10'h3FE); // negative wrap
    tbl[17] = mk(0, 0, 0, 0, 8'h00, 9'h0FE, 1, 0, 4'hF, 10'h3FF);
    tbl[18] = mk(0, 1, 0, 0, 8'h55, HALT_W, 0, 0, 4'hF, 10'h3FF); // halt ignores jmp

    drive(0, 0, 0, 0, 8'h00, NOP);
    reset = 1'b1;
    #1;
    chk("reset_addr",  32'(bus.instr_addr),  32'h0);
    chk("reset_valid", 32'(bus.instr_valid), 32'h0);
    chk("reset_done",  32'(bus.done),        32'h0);
    chk("reset_cnt",   32'(bus.cycle_cnt),   32'h0);
    tick(); tick();
    #2 reset = 1'b0;
    tick();

    // Straight line: 0..4 ordinary, halt word at 5.
    drive(1, 0, 0, 0, 8'h00, NOP);
    step_pc("sl_start_addr", 10'h000);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.instr_in = (i == 5) ? HALT_W : 9'h012;
      #1;
      chk("sl_valid", 32'(bus.instr_valid), (i < 5) ? 32'h1 : 32'h0);
      step_pc("sl_addr", (i < 5) ? 10'(i + 1) : 10'h005);
    end
    chk("sl_done", 32'(bus.done),      32'h1);
    chk("sl_cnt",  32'(bus.cycle_cnt), 32'd5);

    // Restart from HALT.
    drive(1, 0, 0, 0, 8'h00, NOP);
    step_pc("restart_addr", 10'h000);
    chk("restart_done", 32'(bus.done),      32'h0);
    chk("restart_cnt",  32'(bus.cycle_cnt), 32'h0);

    // Control-flow table.
    nvalid = 0;
    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].start, tbl[k].jmp, tbl[k].br, tbl[k].cond, tbl[k].tgt, tbl[k].instr);
      #1;
      chk($sformatf("tbl%0d_valid", k), 32'(bus.instr_valid), 32'(tbl[k].exp_valid));
      chk($sformatf("tbl%0d_typ", k),   32'(bus.typ),         32'(tbl[k].exp_typ));
      chk($sformatf("tbl%0d_op", k),    32'(bus.op),          32'(tbl[k].exp_op));
      if (tbl[k].exp_valid) nvalid++;
      step_pc($sformatf("tbl%0d_pc", k), tbl[k].exp_pc);
    end
    chk("tbl_done", 32'(bus.done),      32'h1);
    chk("tbl_cnt",  32'(bus.cycle_cnt), 32'(nvalid));
    drive(0, 1, 0, 0, 8'h33, NOP);
    #1;
    chk("halt_valid", 32'(bus.instr_valid), 32'h0);
    step_pc("halt_hold_pc", 10'h3FF);
    chk("halt_hold_cnt", 32'(bus.cycle_cnt), 32'(nvalid));

    // Reset mid-run at pc 0x025.
    drive(1, 0, 0, 0, 8'h00, NOP);
    step_pc("rr_start", 10'h000);
    drive(0, 1, 0, 0, 8'h25, NOP);
    step_pc("rr_jump", 10'h025);
    #2 reset = 1'b1;
    #1;
    chk("rr_addr",  32'(bus.instr_addr),  32'h0);
    chk("rr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rr_done",  32'(bus.done),        32'h0);
    chk("rr_cnt",   32'(bus.cycle_cnt),   32'h0);
    #2 reset = 1'b0;
    drive(0, 1, 0, 0, 8'h40, NOP);
    for (int i = 0; i < 10; i++) begin
      step_pc("idle_pc", 10'h000);
      chk("idle_valid", 32'(bus.instr_valid), 32'h0);
    end

    // Saturation: 70000 executed instructions on a 16-bit counter.
    drive(1, 0, 0, 0, 8'h00, NOP);
    tick();
    drive(0, 0, 0, 0, 8'h00, NOP);
    for (int i = 0; i < 70000; i++) tick();
    chk("sat_cnt", 32'(bus.cycle_cnt), 32'hFFFF);
    bus.instr_in = HALT_W;
    tick();
    chk("sat_done",     32'(bus.done),      32'h1);
    chk("sat_cnt_hold", 32'(bus.cycle_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the controller. It owns the program counter, drives the instruction-memory address, and presents the fetched instruction's TYP/OP fields to the controller. It applies the controller's br_ctrl/jmp_ctrl decisions on the next edge, detects the halt instruction, and sequences a program run through IDLE, RUN and HALT with a start/done handshake.

## Interface
- PC_W, 10, program counter / instruction address width
- INSTR_W, 9, instruction width; bit INSTR_W-1 is TYP, bits INSTR_W-2:INSTR_W-5 are OP
- START_ADDR, 0, PC value loaded on reset and on every accepted start
- HALT_INSTR, 9'h0FF, instruction encoding that stops the run
- CNT_W, 16, cycle counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  level-sampled request to begin a run; accepted in IDLE or HALT
- instr_in  in  INSTR_W  instruction-memory read data for instr_addr, combinational same cycle
- br_ctrl  in  1  controller branch request (BTR)
- jmp_ctrl  in  1  controller jump request (JMP)
- br_cond  in  1  branch condition, accumulator bit 0
- target  in  8  register value: signed PC offset for branch, absolute address for jump
- instr_addr  out  PC_W  current PC
- typ  out  1  instr_in[INSTR_W-1]
- op  out  4  instr_in[INSTR_W-2:INSTR_W-5]
- instr_valid  out  1  current instruction is being executed this cycle
- done  out  1  high while in HALT
- cycle_cnt  out  CNT_W  executed-instruction count for the current or last run

## Operation
- States: IDLE (reset state), RUN, HALT.
- IDLE: pc held at START_ADDR; instr_valid=0, done=0. start=1 -> RUN, pc=START_ADDR, cycle_cnt=0.
- RUN, instr_in==HALT_INSTR: instr_valid=0; next state HALT; pc holds; cycle_cnt holds.
- RUN, other instruction: instr_valid=1. Next pc, in priority order:
  - jmp_ctrl=1 -> zero-extended target.
  - br_ctrl=1 and br_cond=1 -> pc + sign-extended target.
  - otherwise -> pc+1.
  - cycle_cnt increments, saturating at all-ones.
- br_ctrl and jmp_ctrl both 1: jump wins. br_ctrl with br_cond=0 -> pc+1.
- PC arithmetic is modulo 2^PC_W: pc at max +1 -> 0; negative offsets wrap.
- HALT: done=1, pc and cycle_cnt held, instr_valid=0. start=1 -> RUN exactly as from IDLE (pc=START_ADDR, cycle_cnt=0). start is ignored in RUN.
- typ/op are combinational slices of instr_in in every state. The controller's outputs are meaningful only when instr_valid=1; downstream write enables must be qualified by instr_valid.

## Timing
- Reset asserted, at any time including mid-run: state=IDLE, instr_addr=START_ADDR, instr_valid=0, done=0, cycle_cnt=0 without waiting for an edge. First start is sampled on the first rising edge after reset deasserts.
- Start latency: start high at edge N (IDLE) -> RUN from edge N; first instruction executes in the cycle after edge N with instr_addr=START_ADDR.
- One instruction per cycle in RUN. A branch or jump decided in cycle k sets instr_addr at edge k+1; there is no delay slot and no bubble.
- Halt: HALT_INSTR present in cycle k -> done=1 after edge k+1. instr_valid is 0 already in cycle k.
- cycle_cnt after a run = number of cycles with instr_valid=1.

## Test plan
- Reset/idle: assert reset mid-RUN at pc=0x025 -> instr_addr=0x000, instr_valid=0, done=0, cycle_cnt=0 immediately; with start held low for 10 cycles, pc stays 0.
- Straight line: start, program 0x000-0x004 non-control, HALT_INSTR at 0x005 -> addresses 0,1,2,3,4,5; done=1 after the next edge; cycle_cnt=5.
- Branch: at pc=0x010, br_ctrl=1, target=8'hFC, br_cond=1 -> next pc=0x00C. Same case with br_cond=0 -> next pc=0x011.
- Jump priority: at pc=0x020, jmp_ctrl=1, br_ctrl=1, br_cond=1, target=8'h80 -> next pc=0x080.
- Wrap: jump to 0x0FF, then branch with target=8'h7F (repeat until pc=0x3FF), then non-control -> pc=0x000. Branch at pc=0x002 with target=8'hFC -> pc=0x3FE.
- Restart/saturation: in HALT, pulse start -> pc=0x000, cycle_cnt=0, done=0 next cycle. Run a 70000-instruction loop with CNT_W=16 -> cycle_cnt holds at 0xFFFF.
